// File: rtl/nzcv_cond_unit_if.sv
// rtl/nzcv_cond_unit_if.sv - condition request / branch result handshake bundle
interface nzcv_cond_unit_if;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       take_valid;
  logic       take;
  logic       take_ready;

  modport master (
    output cond_valid, cond, take_ready,
    input  cond_ready, take_valid, take
  );

  modport slave (
    input  cond_valid, cond, take_ready,
    output cond_ready, take_valid, take
  );
endinterface

// File: rtl/nzcv_cond_unit.sv
// rtl/nzcv_cond_unit.sv - registered NZCV flags, condition evaluator, flag save stack
// Optional FLAG_BYPASS_EN: same-cycle flag_we data feeds an accepted condition request.
module nzcv_cond_unit #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  nzcv_cond_unit_if.slave    cif,
  input  logic               flag_we,
  input  logic               n_in,
  input  logic               c_in,
  input  logic               z_in,
  input  logic               v_in,
  input  logic               push,
  input  logic               pop,
  output logic               stk_full,
  output logic               stk_empty,
  output logic               stk_err,
  output logic [3:0]         flags_out
);

  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 2 ** AW;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [SPW-1:0] sp;
  logic [3:0]     stk [SLOTS];
  logic           take_valid_q;
  logic           take_q;

  logic           accept;
  logic           do_push;
  logic           do_pop;
  logic           op_err;
  logic [SPW-1:0] top;
  logic [3:0]     new_flags;
  logic [3:0]     eval_flags;

  // flags are packed {N,Z,C,V}
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    r = 1'b0;
    case (c)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = cf;
      4'h3: r = !cf;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = cf & !z;
      4'h9: r = !cf | z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = !z & (n == v);
      4'hD: r = z | (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign new_flags      = {n_in, z_in, c_in, v_in};
  assign stk_full       = (sp == SP_MAX);
  assign stk_empty      = (sp == '0);
  assign top            = sp - 1'b1;

  assign cif.cond_ready = !take_valid_q | cif.take_ready;
  assign cif.take_valid = take_valid_q;
  assign cif.take       = take_q;
  assign accept         = cif.cond_valid & cif.cond_ready;

  assign do_push = push & !pop & !stk_full;
  assign do_pop  = pop & !push & !stk_empty;
  assign op_err  = (push & pop) | (push & !pop & stk_full) | (pop & !push & stk_empty);

  // A pop overrides flag_we, so its discarded data must not reach the evaluator either
`ifdef FLAG_BYPASS_EN
  assign eval_flags = (flag_we & !do_pop) ? new_flags : flags_out;
`else
  assign eval_flags = flags_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_out    <= 4'b0000;
      sp           <= '0;
      stk_err      <= 1'b0;
      take_valid_q <= 1'b0;
      take_q       <= 1'b0;
      for (int i = 0; i < SLOTS; i++) stk[i] <= 4'b0000;
    end else begin
      stk_err <= op_err;

      if (do_pop)
        flags_out <= stk[top[AW-1:0]];
      else if (flag_we)
        flags_out <= new_flags;

      // push saves the flags as registered before this cycle's flag_we lands
      if (do_push) begin
        stk[sp[AW-1:0]] <= flags_out;
        sp              <= sp + 1'b1;
      end else if (do_pop) begin
        sp <= top;
      end

      if (accept) begin
        take_valid_q <= 1'b1;
        take_q       <= eval_cond(cif.cond, eval_flags);
      end else if (cif.take_ready) begin
        take_valid_q <= 1'b0;
      end
    end
  end

endmodule
